// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, width helpers and parity function for the UART core
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Bit counter must also span two stop bits on the TX side.
  function automatic int bit_cnt_w(input int clks_per_bit);
    return $clog2(clks_per_bit * 2);
  endfunction

  function automatic int data_cnt_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  // odd = 0 gives even parity, odd = 1 gives odd parity.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - synchronised mid-bit sampling UART receiver
module uart_rx_engine import uart_pkg::*; #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 parity_type,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = bit_cnt_w(CLKS_PER_BIT);
  localparam int IDX_W = data_cnt_w(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_state_e          state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 sync1, sync2, sync3;
  logic                 par_s, ptype, fell, sample, bit_end;

  assign fell    = sync3 & ~sync2;
  assign bit_end = (cnt == BIT_LAST);
  assign rx_busy = (state != IDLE);

  always_comb begin
    state_n = state;
    sample  = 1'b0;
    case (state)
      IDLE:   if (fell) state_n = START;
      START:  if (cnt == HALF_LAST) begin
                sample  = 1'b1;
                state_n = sync2 ? IDLE : DATA;
              end
      DATA:   if (bit_end) begin
                sample = 1'b1;
                if (idx == IDX_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
              end
      PARITY: if (bit_end) begin
                sample  = 1'b1;
                state_n = STOP;
              end
      STOP:   if (bit_end) begin
                sample  = 1'b1;
                state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync3      <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_s      <= 1'b0;
      ptype      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1    <= rx_in;
      sync2    <= sync1;
      sync3    <= sync2;
      state    <= state_n;
      cnt      <= (sample || state == IDLE) ? '0 : cnt + 1'b1;
      rx_valid <= 1'b0;
      // Parity sense is captured on the start edge and held for the frame.
      if (state == IDLE) begin
        idx   <= '0;
        ptype <= parity_type;
      end
      if (sample) begin
        case (state)
          DATA: begin
            shreg <= {sync2, shreg[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
          end
          PARITY: par_s <= sync2;
          STOP: begin
            rx_data    <= shreg;
            rx_valid   <= 1'b1;
            frame_err  <= ~sync2;
            parity_err <= (PARITY_EN != 0) && (par_s != calc_parity(MAX_DATA_BITS'(shreg), ptype));
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - single-clock parametrised UART: TX FSM, loopback mux, RX engine
module uart_core_param import uart_pkg::*; #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_type,
  input  logic                 loopback,
  output logic                 tx_serialout,
  input  logic                 rx_serialin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 tx_busy,
  output logic                 rx_busy
);

  localparam int CNT_W = bit_cnt_w(CLKS_PER_BIT);
  localparam int IDX_W = data_cnt_w(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  // The IDLE cycle that follows STOP is the final stop cycle, so back-to-back frames are gapless.
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_state_e          state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, line, line_n, bit_end, shift, rx_line;

  assign bit_end      = (cnt == BIT_LAST);
  assign tx_ready     = (state == IDLE);
  assign tx_busy      = (state != IDLE);
  assign tx_serialout = line;
  assign rx_line      = loopback ? line : rx_serialin;

  always_comb begin
    state_n = state;
    shift   = 1'b0;
    case (state)
      IDLE:   if (tx_valid) state_n = START;
      START:  if (bit_end) state_n = DATA;
      DATA:   if (bit_end) begin
                shift = 1'b1;
                if (idx == IDX_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
              end
      PARITY: if (bit_end) state_n = STOP;
      STOP:   if (cnt == STOP_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift ? shreg[1] : shreg[0];
      PARITY:  line_n = par_bit;
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      line    <= 1'b1;
    end else begin
      state <= state_n;
      line  <= line_n;
      cnt   <= (state_n != state || shift || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == IDLE && tx_valid) begin
        shreg   <= tx_data;
        par_bit <= calc_parity(MAX_DATA_BITS'(tx_data), parity_type);
        idx     <= '0;
      end else if (shift) begin
        shreg <= shreg >> 1;
        idx   <= idx + 1'b1;
      end
    end
  end

  uart_rx_engine #(
    .DATA_BITS   (DATA_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY_EN   (PARITY_EN)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_line),
    .parity_type(parity_type),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

endmodule

// File: doc/uart_core_param.md
# uart_core_param

Parametrised single-clock UART engine: the next generation of the team's UART top level. It replaces the separate tx/rx clocks with one system clock and an internal per-bit counter. It also adds configurable data length, stop bits and runtime parity selection, plus an internal loopback mode. The block sits between parallel producer/consumer logic, using a valid/ready handshake, and the serial pins.

## Interface
- DATA_BITS, 8: payload width per frame, legal 5..9
- CLKS_PER_BIT, 16: clk cycles per serial bit, legal ≥4, even
- PARITY_EN, 0: 1 inserts/checks one parity bit after the payload
- STOP_BITS, 1: 1 or 2 stop bits transmitted

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- tx_data  in  DATA_BITS  payload to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  engine idle, accepts tx_data
- parity_type  in  1  0 = even, 1 = odd; sampled at frame start
- loopback  in  1  1 = RX input taken from internal TX line
- tx_serialout  out  1  serial output, idle high
- rx_serialin  in  1  asynchronous serial input
- rx_data  out  DATA_BITS  last received payload
- rx_valid  out  1  one-cycle pulse: rx_data/errors valid
- parity_err  out  1  parity mismatch, qualified by rx_valid
- frame_err  out  1  stop bit sampled low, qualified by rx_valid
- tx_busy, rx_busy  out  1  engine not in IDLE

## Operation
- Reset values: tx_serialout=1, tx_ready=1, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, tx_busy=0, rx_busy=0. Both FSMs go to IDLE and all counters clear.
- TX FSM states: IDLE → START → DATA → PARITY (only if PARITY_EN) → STOP → IDLE.
  - Handshake happens on tx_valid && tx_ready at a clk edge.
  - On handshake, tx_data and parity_type are latched into a shift register.
  - Each state lasts CLKS_PER_BIT cycles. STOP lasts STOP_BITS×CLKS_PER_BIT cycles.
  - DATA is sent LSB first.
  - Parity bit = ^data XOR parity_type.
- RX path uses a 2-FF synchroniser on the selected input (rx_serialin, or the internal TX line when loopback=1). Changing loopback mid-frame is undefined.
- RX FSM states: IDLE → START → DATA → PARITY (if PARITY_EN) → STOP → IDLE.
  - IDLE: a synchronised falling edge enters START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. High means false start: return to IDLE with no rx_valid.
  - Every later bit is sampled CLKS_PER_BIT cycles after the previous sample, so sampling stays at mid-bit.
  - Only the first stop bit is checked. The receiver returns to IDLE right after that sample, so it can accept a back-to-back frame even when the transmitter uses 2 stop bits.
- On the first-stop sample, all of the following update in the same edge: rx_data is loaded, parity_err and frame_err are updated, and rx_valid pulses. The payload is delivered even if an error flag is set.
- parity_err is forced 0 when PARITY_EN=0.
- There is no RX buffering. A new frame overwrites rx_data; the consumer must capture it on rx_valid.

## Timing
- TX: handshake at edge N → tx_serialout low from edge N+1. tx_ready is low from edge N+1 through the end of the last stop bit.
- TX frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS)×CLKS_PER_BIT cycles. tx_ready is high on the cycle after the last stop cycle.
- tx_valid held high with new data gives back-to-back frames with no idle gap.
- RX latency: the rx_valid edge is 2 (synchroniser) + CLKS_PER_BIT/2 + (DATA_BITS+PARITY_EN+1)×CLKS_PER_BIT cycles after the input falling edge, ±1 cycle of edge-detect quantisation.
- In loopback with STOP_BITS=1, rx_valid pulses before tx_ready returns high.
- Reset mid-frame: at the next edge where rst=0, tx_serialout=1 and any partial RX frame is discarded with no rx_valid.

## Structure
- Package uart_pkg holds:
  - the shared state enum (IDLE, START, DATA, PARITY, STOP)
  - a parity function (data, type)
  - localparam widths: bit counter $clog2(CLKS_PER_BIT×2), data counter $clog2(DATA_BITS+1)
- One natural sub-module, uart_rx_engine, containing the synchroniser, FSM and sampling. TX FSM and loopback mux stay in uart_core_param.

## Test plan
- Defaults (8N1, CLKS_PER_BIT=16), send 0xA5 → line bits 0,1,0,1,0,0,1,0,1,1 at 16 cycles each. tx_ready is low for 160 cycles. With loopback=1, rx_data=0xA5 and rx_valid pulses once with both error flags 0.
- PARITY_EN=1, parity_type=0, send 0x07 → parity bit 1. With parity_type=1 → parity bit 0. Loopback gives parity_err=0 in both cases.
- External rx_serialin frame 0x3C with the parity bit flipped → rx_valid with rx_data=0x3C and parity_err=1. Frame 0x3C with stop bit low → frame_err=1.
- Glitch on rx_serialin: low for 4 cycles, then high → no rx_valid, rx_busy returns to 0 within CLKS_PER_BIT cycles.
- DATA_BITS=5, STOP_BITS=2, three back-to-back frames 0x1F, 0x00, 0x15 with tx_valid held high → gapless line. Loopback yields three rx_valid pulses with matching data.
- rst driven low for 1 cycle mid DATA bit 3 → tx_serialout=1 next edge, tx_ready=1, no rx_valid. A subsequent frame 0x5A is received correctly.
